bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 12 +
 rtl/dabble_digit.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter
// and the seven-segment display decoder.
package bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Nibble code the display decoder shows as blank.
  localparam logic [3:0] BLANK_NIB = 4'hF;

endpackage

// File: rtl/dabble_digit.sv
// Double-dabble correction for one BCD nibble:
// add 3 when the digit is 5 or more.
module dabble_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-shift correction so the doubled digit carries
  // into the next nibble at decimal ten.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per
// cycle, with overflow blanking.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int MAX_VAL = 10**N_DIGITS - 1;

  localparam logic [BIN_W-1:0] MAX_BIN =
    BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_IT =
    CNT_W'(BIN_W - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             err_q, err_d;

  logic [BCD_W-1:0] acc_fix;
  logic [BCD_W-1:0] acc_shl;
  logic [BIN_W-1:0] sr_shl;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    dabble_digit u_dig (
      .din  (acc_q[4*i +: 4]),
      .dout (acc_fix[4*i +: 4])
    );
  end

  assign acc_shl = {acc_fix[BCD_W-2:0], sr_q[BIN_W-1]};
  assign sr_shl  = {sr_q[BIN_W-2:0], 1'b0};

  // Next-state: accept/reject in IDLE, iterate in
  // SHIFT, single-cycle DONE back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bin > MAX_BIN) begin
            bcd_d   = {N_DIGITS{BLANK_NIB}};
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            sr_d    = bin;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shl;
        sr_d  = sr_shl;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          bcd_d   = acc_shl;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, reset wins.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign bcd  = bcd_q;
  assign err  = err_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq with a
// decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  bin_to_bcd_seq #(
    .N_DIGITS (4),
    .BIN_W    (14)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start, waits for done (bounded),
  // then one more cycle to observe done falling.
  task automatic run_conv(
    input  int          v,
    output int          lat,
    output logic [15:0] res,
    output logic        res_err,
    output logic        busy_ok,
    output logic        narrow
  );
    start = 1'b1;
    bin   = 14'(v);
    tick();
    start = 1'b0;
    bin   = 14'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    res = bcd;
    res_err = err;
    tick();
    narrow = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    bin = 14'd1234;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if ({bcd, err, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset: bcd=%h err=%b busy=%b done=%b req 0",
               bcd, err, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b req 0",
               busy, done);
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [15:0] r;
    logic e, bok, nar;
    run_conv(0, lat, r, e, bok, nar);
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL zero_latency: got %0d req 14", lat);
    end
    checks++;
    if (r !== 16'h0000 || e !== 1'b0) begin
      errors++;
      $display("FAIL zero_value: bcd=%h err=%b req 0000/0",
               r, e);
    end
    checks++;
    if (bok !== 1'b1 || nar !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy_done: busy_ok=%b narrow=%b req 1/1",
               bok, nar);
    end
  endtask

  task automatic test_values();
    int vals [3] = '{1234, 9999, 9};
    int lat;
    logic [15:0] r;
    logic e, bok, nar;
    foreach (vals[k]) begin
      run_conv(vals[k], lat, r, e, bok, nar);
      checks++;
      if (r !== ref_bcd(vals[k]) || e !== 1'b0
          || lat !== 14) begin
        errors++;
        $display("FAIL value_%0d: bcd=%h err=%b lat=%0d req %h/0/14",
                 vals[k], r, e, lat, ref_bcd(vals[k]));
      end
    end
  endtask

  task automatic test_overflow();
    int vals [2] = '{10000, 16383};
    int lat;
    logic [15:0] r;
    logic e, bok, nar;
    foreach (vals[k]) begin
      run_conv(vals[k], lat, r, e, bok, nar);
      checks++;
      if (r !== 16'hFFFF || e !== 1'b1 || lat !== 0
          || nar !== 1'b1) begin
        errors++;
        $display("FAIL overflow_%0d: bcd=%h err=%b lat=%0d req FFFF/1/0",
                 vals[k], r, e, lat);
      end
    end
    checks++;
    if (bcd !== 16'hFFFF || err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold: bcd=%h err=%b req FFFF/1",
               bcd, err);
    end
    run_conv(42, lat, r, e, bok, nar);
    checks++;
    if (r !== 16'h0042 || e !== 1'b0 || lat !== 14) begin
      errors++;
      $display("FAIL after_overflow: bcd=%h err=%b lat=%0d req 0042/0/14",
               r, e, lat);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [15:0] last;
    logic held;
    logic [15:0] prev;
    prev = bcd;
    held = 1'b1;
    pulses = 0;
    last = '0;
    start = 1'b1;
    bin = 14'd500;
    tick();
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) begin
        start = 1'b1;
        bin = 14'd7;
      end else begin
        start = 1'b0;
        bin = 14'($urandom_range(0, 9999));
      end
      if (busy && bcd !== prev) held = 1'b0;
      if (done) begin
        pulses++;
        last = bcd;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d req 1", pulses);
    end
    checks++;
    if (last !== 16'h0500) begin
      errors++;
      $display("FAIL ignore_value: bcd=%h req 0500", last);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL bcd_hold_shift: held=%b req 1", held);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    logic [15:0] r;
    logic e, bok, nar;
    start = 1'b1;
    bin = 14'd8765;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({bcd, err, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL abort_state: bcd=%h err=%b busy=%b done=%b req 0",
               bcd, err, busy, done);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_quiet: active cycles %0d req 0", pulses);
    end
    run_conv(8765, lat, r, e, bok, nar);
    checks++;
    if (r !== 16'h8765 || e !== 1'b0 || lat !== 14) begin
      errors++;
      $display("FAIL abort_retry: bcd=%h err=%b lat=%0d req 8765/0/14",
               r, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    int v;
    int lat;
    logic [15:0] r;
    logic e, bok, nar;
    for (int k = 0; k < 25; k++) begin
      v = int'($urandom_range(0, 9999));
      run_conv(v, lat, r, e, bok, nar);
      checks++;
      if (r !== ref_bcd(v) || e !== 1'b0 || lat !== 14
          || nar !== 1'b1 || bok !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: bin=%0d bcd=%h err=%b lat=%0d narrow=%b req %h/0/14/1",
                 k, v, r, e, lat, nar, ref_bcd(v));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
